// File: rtl/march_bist_sequencer_if.sv
// march_bist_sequencer_if
// Groups every non-clock signal of the March C- BIST sequencer.
//   slave  : the sequencer side. Inputs are start, the functional port
//            (func_we/func_addr/func_din) and the RAM read data (sram_dout).
//            Outputs are the RAM port (sram_we/sram_addr/sram_din), the
//            status flags (busy, done, fail) and the capture results
//            (fail_addr, fail_elem, fail_count).
//   master : the environment side, i.e. the functional user, the RAM and
//            the test controller.
interface march_bist_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 4,
  parameter int CNT_W  = 4
) ();
  logic              start;
  logic              func_we;
  logic [ADDR_W-1:0] func_addr;
  logic [WORD_W-1:0] func_din;
  logic [WORD_W-1:0] sram_dout;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [WORD_W-1:0] sram_din;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [CNT_W-1:0]  fail_count;

  modport slave (
    input  start, func_we, func_addr, func_din, sram_dout,
    output sram_we, sram_addr, sram_din, busy, done, fail,
           fail_addr, fail_elem, fail_count
  );

  modport master (
    output start, func_we, func_addr, func_din, sram_dout,
    input  sram_we, sram_addr, sram_din, busy, done, fail,
           fail_addr, fail_elem, fail_count
  );
endinterface

// File: rtl/march_bist_sequencer.sv
// march_bist_sequencer
// March C- test sequencer and port arbiter for a single-port SRAM with a
// synchronous read. While idle, the functional port passes straight through
// to the RAM. A start request takes the RAM over and runs the six March C-
// elements. The block records the first failing address and element, counts
// miscompares (saturating), then hands the RAM back and reports done and
// pass/fail.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : march_bist_sequencer_if.slave (start, functional port, RAM port,
//         status and results)
module march_bist_sequencer #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  march_bist_sequencer_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Elements 3 and 4 walk the address space downwards.
  function automatic logic elem_is_down(input logic [2:0] e);
    case (e)
      3'd3, 3'd4: elem_is_down = 1'b1;
      default:    elem_is_down = 1'b0;
    endcase
  endfunction

  // Elements 1..4 hold a read followed by a write; 0 and 5 hold a single op.
  function automatic logic elem_two_ops(input logic [2:0] e);
    case (e)
      3'd1, 3'd2, 3'd3, 3'd4: elem_two_ops = 1'b1;
      default:                elem_two_ops = 1'b0;
    endcase
  endfunction

  logic [1:0]        state_q,      state_d;
  logic [2:0]        elem_q,       elem_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic              op_q,         op_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;
  logic              fail_q,       fail_d;
  logic [ADDR_W-1:0] fail_addr_q,  fail_addr_d;
  logic [2:0]        fail_elem_q,  fail_elem_d;
  logic [CNT_W-1:0]  fail_count_q, fail_count_d;
  logic              cmp_valid_q,  cmp_valid_d;
  logic [WORD_W-1:0] cmp_exp_q,    cmp_exp_d;
  logic [ADDR_W-1:0] cmp_addr_q,   cmp_addr_d;
  logic [2:0]        cmp_elem_q,   cmp_elem_d;

  logic              op_read_s;
  logic              op_data_s;
  logic [WORD_W-1:0] op_word_s;
  logic              seq_we_s;
  logic [WORD_W-1:0] seq_din_s;
  logic [2:0]        elem_inc_s;
  logic [ADDR_W-1:0] last_addr_s;

  // Decode the current op: read or write, and the data background (D0/D1).
  always_comb begin
    op_read_s = 1'b0;
    op_data_s = 1'b0;
    case (elem_q)
      3'd0: begin op_read_s = 1'b0;   op_data_s = 1'b0;   end  // w0
      3'd1: begin op_read_s = ~op_q;  op_data_s = op_q;   end  // r0,w1
      3'd2: begin op_read_s = ~op_q;  op_data_s = ~op_q;  end  // r1,w0
      3'd3: begin op_read_s = ~op_q;  op_data_s = op_q;   end  // r0,w1
      3'd4: begin op_read_s = ~op_q;  op_data_s = ~op_q;  end  // r1,w0
      3'd5: begin op_read_s = 1'b1;   op_data_s = 1'b0;   end  // r0
      default: begin op_read_s = 1'b0; op_data_s = 1'b0;  end
    endcase
  end

  assign op_word_s   = {WORD_W{op_data_s}};
  assign seq_we_s    = (state_q == ST_RUN) && !op_read_s;
  assign seq_din_s   = seq_we_s ? op_word_s : {WORD_W{1'b0}};
  assign elem_inc_s  = elem_q + 3'd1;
  assign last_addr_s = elem_is_down(elem_q) ? {ADDR_W{1'b0}} : ADDR_MAX;

  // RAM port arbitration: functional port whenever the BIST is not busy.
  always_comb begin
    if (busy_q) begin
      bus.sram_we   = seq_we_s;
      bus.sram_addr = addr_q;
      bus.sram_din  = seq_din_s;
    end else begin
      bus.sram_we   = bus.func_we;
      bus.sram_addr = bus.func_addr;
      bus.sram_din  = bus.func_din;
    end
  end

  // Sequencer next state: op/address/element stepping, compare and capture.
  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    addr_d       = addr_q;
    op_d         = op_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;
    fail_elem_d  = fail_elem_q;
    fail_count_d = fail_count_q;
    cmp_valid_d  = 1'b0;
    cmp_exp_d    = cmp_exp_q;
    cmp_addr_d   = cmp_addr_q;
    cmp_elem_d   = cmp_elem_q;

    // A read registered last cycle has its data on sram_dout now.
    if (cmp_valid_q && (bus.sram_dout != cmp_exp_q)) begin
      if (fail_count_q != CNT_MAX) begin
        fail_count_d = fail_count_q + CNT_ONE;
      end else begin
        fail_count_d = fail_count_q;
      end
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
      end else begin
        fail_d      = fail_q;
      end
    end else begin
      fail_count_d = fail_count_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d      = ST_RUN;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          fail_addr_d  = {ADDR_W{1'b0}};
          fail_elem_d  = 3'd0;
          fail_count_d = {CNT_W{1'b0}};
          elem_d       = 3'd0;
          addr_d       = {ADDR_W{1'b0}};
          op_d         = 1'b0;
        end else begin
          state_d      = state_q;
        end
      end
      ST_RUN: begin
        if (op_read_s) begin
          cmp_valid_d = 1'b1;
          cmp_exp_d   = op_word_s;
          cmp_addr_d  = addr_q;
          cmp_elem_d  = elem_q;
        end else begin
          cmp_valid_d = 1'b0;
        end
        if (elem_two_ops(elem_q) && !op_q) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (addr_q != last_addr_s) begin
            addr_d = elem_is_down(elem_q) ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          end else if (elem_q == 3'd5) begin
            state_d = ST_DRAIN;
          end else begin
            // Next element starts immediately at its own start address.
            elem_d = elem_inc_s;
            addr_d = elem_is_down(elem_inc_s) ? ADDR_MAX : {ADDR_W{1'b0}};
          end
        end
      end
      ST_DRAIN: begin
        // Final compare happens here while the functional port stays blocked.
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      elem_q       <= 3'd0;
      addr_q       <= {ADDR_W{1'b0}};
      op_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_addr_q  <= {ADDR_W{1'b0}};
      fail_elem_q  <= 3'd0;
      fail_count_q <= {CNT_W{1'b0}};
      cmp_valid_q  <= 1'b0;
      cmp_exp_q    <= {WORD_W{1'b0}};
      cmp_addr_q   <= {ADDR_W{1'b0}};
      cmp_elem_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
      fail_elem_q  <= fail_elem_d;
      fail_count_q <= fail_count_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_exp_q    <= cmp_exp_d;
      cmp_addr_q   <= cmp_addr_d;
      cmp_elem_q   <= cmp_elem_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fail       = fail_q;
  assign bus.fail_addr  = fail_addr_q;
  assign bus.fail_elem  = fail_elem_q;
  assign bus.fail_count = fail_count_q;

endmodule

// File: tb/tb_march_bist_sequencer.sv
// Testbench for march_bist_sequencer: a behavioural 256x4 synchronous-read
// RAM with injectable faults, a scoreboard of expected ops and run results,
// and a monitor that compares them as the DUT presents ops and done.
module tb_march_bist_sequencer;

  localparam int N = 256;

  logic clk;
  logic rst;

  march_bist_sequencer_if #(.ADDR_W(8), .WORD_W(4), .CNT_W(4)) bus ();

  march_bist_sequencer #(.ADDR_W(8), .WORD_W(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 0 = good, 1 = bit 2 stuck-at-0 at 0x3A, 2 = reads stuck at 4'hF.
  int         fault_mode;
  logic [3:0] mem [N];
  logic [3:0] ram_q;

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 4'h0;
    ram_q = 4'h0;
  end

  always @(posedge clk) begin
    if (bus.sram_we) begin
      if (fault_mode == 1 && bus.sram_addr == 8'h3A) mem[bus.sram_addr] <= bus.sram_din & 4'b1011;
      else                                           mem[bus.sram_addr] <= bus.sram_din;
    end
    ram_q <= (fault_mode == 2) ? 4'hF : mem[bus.sram_addr];
  end
  assign bus.sram_dout = ram_q;

  // Scoreboard.
  typedef struct {
    int         k;
    logic       we;
    logic [7:0] addr;
    logic [3:0] din;
  } op_t;

  typedef struct {
    int         cyc;
    logic       f;
    logic [7:0] a;
    logic [2:0] e;
    logic [3:0] c;
  } res_t;

  op_t  op_exp_q[$];
  res_t res_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_events = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_op(input int k, input logic we, input logic [7:0] a, input logic [3:0] d);
    op_t o;
    o.k = k; o.we = we; o.addr = a; o.din = d;
    op_exp_q.push_back(o);
  endtask

  task automatic push_res(input logic f, input logic [7:0] a, input logic [2:0] e, input logic [3:0] c);
    res_t r;
    r.cyc = 10 * N + 1; r.f = f; r.a = a; r.e = e; r.c = c;
    res_q.push_back(r);
  endtask

  // Monitor: counts busy cycles, checks scheduled ops, checks results at done.
  initial begin
    int   cyc;
    logic busy_prev;
    logic done_prev;
    op_t  o;
    res_t r;
    cyc = 0;
    busy_prev = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.busy) begin
        if (!busy_prev) cyc = 1;
        else            cyc++;
        if (op_exp_q.size() > 0 && op_exp_q[0].k == cyc) begin
          o = op_exp_q.pop_front();
          check($sformatf("op%0d_we", o.k),   {31'd0, bus.sram_we}, {31'd0, o.we});
          check($sformatf("op%0d_addr", o.k), {24'd0, bus.sram_addr}, {24'd0, o.addr});
          check($sformatf("op%0d_din", o.k),  {28'd0, bus.sram_din}, {28'd0, o.din});
        end
      end
      if (bus.done && !done_prev) begin
        if (res_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_done: got done with no expected result queued");
        end else begin
          r = res_q.pop_front();
          check("busy_cycles", cyc, r.cyc);
          check("fail",        {31'd0, bus.fail}, {31'd0, r.f});
          check("fail_addr",   {24'd0, bus.fail_addr}, {24'd0, r.a});
          check("fail_elem",   {29'd0, bus.fail_elem}, {29'd0, r.e});
          check("fail_count",  {28'd0, bus.fail_count}, {28'd0, r.c});
        end
        done_events++;
      end
      busy_prev = bus.busy;
      done_prev = bus.done;
    end
  end

  task automatic start_pulse();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int budget);
    int c;
    c = 0;
    while (done_events == n0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (done_events == n0) begin
      total_cnt++;
      $display("FAIL wait_done: no done within %0d cycles", budget);
    end
  endtask

  // Functional write then read-back through the pass-through path.
  task automatic passthru(input string tag, input logic [3:0] d);
    @(negedge clk);
    bus.func_we = 1'b1; bus.func_addr = 8'h10; bus.func_din = d;
    #1;
    check({tag, "_mux_we"},   {31'd0, bus.sram_we},   32'd1);
    check({tag, "_mux_addr"}, {24'd0, bus.sram_addr}, 32'h10);
    check({tag, "_mux_din"},  {28'd0, bus.sram_din},  {28'd0, d});
    @(negedge clk);
    bus.func_we = 1'b0;
    #1;
    check({tag, "_mux_rd"}, {31'd0, bus.sram_we}, 32'd0);
    @(negedge clk);
    check({tag, "_rdata"}, {28'd0, bus.sram_dout}, {28'd0, d});
  endtask

  initial begin
    int n0;
    int c;
    rst = 1'b0;
    fault_mode = 0;
    bus.start = 1'b0;
    bus.func_we = 1'b0;
    bus.func_addr = 8'h00;
    bus.func_din = 4'h0;
    #12 rst = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_fail", {31'd0, bus.fail}, 32'd0);
    check("rst_fail_count", {28'd0, bus.fail_count}, 32'd0);

    passthru("idle", 4'h9);

    // Clean run; functional write attempts during RUN must be ignored.
    push_op(1,    1'b1, 8'h00, 4'h0);
    push_op(257,  1'b0, 8'h00, 4'h0);
    push_op(258,  1'b1, 8'h00, 4'hF);
    push_op(1281, 1'b0, 8'hFF, 4'h0);
    push_res(1'b0, 8'h00, 3'd0, 4'h0);
    n0 = done_events;
    start_pulse();
    repeat (10) @(negedge clk);
    bus.func_we = 1'b1; bus.func_addr = 8'h10; bus.func_din = 4'h5;
    repeat (2000) @(negedge clk);
    bus.func_we = 1'b0;
    wait_done(n0, 3000);
    check("ops_consumed", op_exp_q.size(), 32'd0);
    @(negedge clk);
    check("done_hold", {31'd0, bus.done}, 32'd1);
    // e4 leaves zeros everywhere; the 4'h5 from RUN must not be there.
    bus.func_addr = 8'h10;
    @(negedge clk);
    @(negedge clk);
    check("run_we_blocked", {28'd0, bus.sram_dout}, 32'h0);
    passthru("done", 4'h9);

    // Bit 2 stuck-at-0 at 0x3A.
    fault_mode = 1;
    push_res(1'b1, 8'h3A, 3'd2, 4'h2);
    n0 = done_events;
    start_pulse();
    wait_done(n0, 3000);

    // Whole RAM reads 4'hF, start held high across two back-to-back runs.
    fault_mode = 2;
    push_res(1'b1, 8'h00, 3'd1, 4'hF);
    push_res(1'b1, 8'h00, 3'd1, 4'hF);
    n0 = done_events;
    @(negedge clk);
    bus.start = 1'b1;
    wait_done(n0, 3000);
    c = 0;
    while (!bus.busy && c < 10) begin
      @(negedge clk);
      c++;
    end
    check("restart_busy", {31'd0, bus.busy}, 32'd1);
    check("restart_done_clr", {31'd0, bus.done}, 32'd0);
    check("restart_fail_clr", {31'd0, bus.fail}, 32'd0);
    check("restart_cnt_clr", {28'd0, bus.fail_count}, 32'd0);
    n0 = done_events;
    repeat (50) @(negedge clk);
    bus.start = 1'b0;
    wait_done(n0, 3000);

    // Asynchronous reset mid-run.
    fault_mode = 0;
    start_pulse();
    repeat (1005) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_fail", {31'd0, bus.fail}, 32'd0);
    check("arst_fail_addr", {24'd0, bus.fail_addr}, 32'd0);
    check("arst_fail_elem", {29'd0, bus.fail_elem}, 32'd0);
    check("arst_fail_count", {28'd0, bus.fail_count}, 32'd0);
    bus.func_we = 1'b1; bus.func_addr = 8'h20; bus.func_din = 4'h3;
    #1;
    check("arst_mux_we",   {31'd0, bus.sram_we},   32'd1);
    check("arst_mux_addr", {24'd0, bus.sram_addr}, 32'h20);
    check("arst_mux_din",  {28'd0, bus.sram_din},  32'h3);
    bus.func_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    push_res(1'b0, 8'h00, 3'd0, 4'h0);
    n0 = done_events;
    start_pulse();
    wait_done(n0, 3000);
    check("res_consumed", res_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
